display_scan_driver: RTL and testbench

Time-multiplexed scan and serial-output stage for the six-digit 7-segment clock display. It steps the digit select (0..5) into `clock_to_7seg`, captures the returned segment byte, and shifts it with a one-hot digit-enable byte into an external 16-bit serial-in/parallel-out register chain (74HC595-style), then pulses the register latch and holds the digit lit for a dwell period. It sits directly downstream of the time registers, and both drives and consumes the segment-conversion stage.

---
 rtl/display_scan_driver_if.sv | 33 +++
 rtl/display_scan_driver.sv | 132 +++++++++++++
 tb/tb_display_scan_driver.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_driver_if.sv
// Signal bundle between the display scan driver and the segment converter / 74HC595 chain.
// The spec-fixed signal names are kept so the bundle matches the block's pin list.
interface display_scan_driver_if;
    logic [7:0] i_7seg;
    logic       i_blank;
    logic [3:0] o_seg_select;
    logic       o_sclk;
    logic       o_sdata;
    logic       o_latch;
    logic       o_frame_start;

    // Scan driver side.
    modport master (
        input  i_7seg,
        input  i_blank,
        output o_seg_select,
        output o_sclk,
        output o_sdata,
        output o_latch,
        output o_frame_start
    );

    // Converter and shift-register side.
    modport slave (
        output i_7seg,
        output i_blank,
        input  o_seg_select,
        input  o_sclk,
        input  o_sdata,
        input  o_latch,
        input  o_frame_start
    );
endinterface

// File: rtl/display_scan_driver.sv
// Six-digit 7-segment scan driver: selects a digit, captures its segment byte and
// shifts {seg, 2'b00, onehot} into an external 16-bit SIPO chain, then latches and dwells.
module display_scan_driver #(
    parameter int unsigned SCLK_DIV     = 2,
    parameter int unsigned DWELL_CYCLES = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    display_scan_driver_if.master  bus
);

    localparam int unsigned HALF_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned DWELL_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned DIGITS     = 6;
    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(SCLK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [3:0]         LAST_DIGIT = 4'(DIGITS - 1);
    localparam logic [3:0]         LAST_BIT   = 4'd15;

    typedef enum logic [2:0] {
        SELECT,
        CAPTURE,
        SHIFT,
        LATCH,
        DWELL
    } state_t;

    state_t               state;
    logic [3:0]           digit;
    logic [14:0]          rest;
    logic [3:0]           bit_cnt;
    logic [HALF_W-1:0]    half_cnt;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic                 sclk;
    logic                 sdata;
    logic                 latch;
    logic                 frame_start;

    logic [7:0]           seg_c;
    logic [5:0]           onehot_c;

    // Segment byte and digit enable as seen at capture time.
    assign seg_c    = bus.i_blank ? 8'h00 : bus.i_7seg;
    assign onehot_c = 6'd1 << digit;

    // Scan sequencer. The first word bit goes out directly from the captured byte, so
    // only the remaining 15 bits need to be held for shifting.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= SELECT;
            digit       <= '0;
            rest        <= '0;
            bit_cnt     <= '0;
            half_cnt    <= '0;
            dwell_cnt   <= '0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            latch       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            case (state)
                SELECT: begin
                    frame_start <= (digit == 4'd0);
                    state       <= CAPTURE;
                end

                CAPTURE: begin
                    frame_start <= 1'b0;
                    rest        <= {seg_c[6:0], 2'b00, onehot_c};
                    sdata       <= seg_c[7];
                    sclk        <= 1'b0;
                    half_cnt    <= '0;
                    bit_cnt     <= '0;
                    state       <= SHIFT;
                end

                SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                sdata <= 1'b0;
                                latch <= 1'b1;
                                state <= LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sdata   <= rest[14];
                                rest    <= {rest[13:0], 1'b0};
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end
                end

                LATCH: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt  <= '0;
                        latch     <= 1'b0;
                        dwell_cnt <= '0;
                        state     <= DWELL;
                    end else begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end
                end

                DWELL: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        digit <= (digit == LAST_DIGIT) ? 4'd0 : digit + 4'd1;
                        state <= SELECT;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end

                default: begin
                    state <= SELECT;
                end
            endcase
        end
    end

    assign bus.o_seg_select  = digit;
    assign bus.o_sclk        = sclk;
    assign bus.o_sdata       = sdata;
    assign bus.o_latch       = latch;
    assign bus.o_frame_start = frame_start;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with SCLK_DIV=1, DWELL_CYCLES=4 (39-cycle digit period).
module tb_display_scan_driver;

    logic clk;
    logic rst_n;
    int unsigned cyc;

    display_scan_driver_if bus ();

    display_scan_driver #(
        .SCLK_DIV     (1),
        .DWELL_CYCLES (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release; the first edge after release is cycle 1.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int unsigned cyc;
        logic [15:0] word;
        int unsigned nbits;
        int unsigned len;
        logic [3:0]  sel;
    } lat_t;

    lat_t        lat_q[$];
    int unsigned fs_cyc_q[$];
    logic [3:0]  fs_sel_q[$];
    lat_t        cur;
    logic [15:0] rx;
    int unsigned nbits;
    logic        prev_sclk;
    logic        prev_latch;
    int unsigned line_err = 0;
    int unsigned rst_err  = 0;

    // Model of the external 74HC595 chain: shift on sclk rise, snapshot on latch.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx         = '0;
            nbits      = 0;
            prev_sclk  = 1'b0;
            prev_latch = 1'b0;
            if (bus.o_sclk || bus.o_sdata || bus.o_latch || bus.o_frame_start
                || bus.o_seg_select != 4'd0)
                rst_err++;
        end else begin
            if (bus.o_sclk && !prev_sclk) begin
                rx = {rx[14:0], bus.o_sdata};
                nbits++;
            end
            if (bus.o_latch) begin
                if (!prev_latch) begin
                    cur.cyc   = cyc;
                    cur.word  = rx;
                    cur.nbits = nbits;
                    cur.sel   = bus.o_seg_select;
                    cur.len   = 1;
                    rx        = '0;
                    nbits     = 0;
                end else begin
                    cur.len++;
                end
                if (bus.o_sclk || bus.o_sdata) line_err++;
            end else if (prev_latch) begin
                lat_q.push_back(cur);
            end
            if (bus.o_frame_start) begin
                fs_cyc_q.push_back(cyc);
                fs_sel_q.push_back(bus.o_seg_select);
            end
            if (bus.o_seg_select > 4'd5) line_err++;
            prev_sclk  = bus.o_sclk;
            prev_latch = bus.o_latch;
        end
    end

    task automatic wait_cyc(input int unsigned target);
        int unsigned b = 0;
        while (cyc != target && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        check($sformatf("wait_cyc_%0d", target), cyc, target);
    endtask

    task automatic wait_latches(input int unsigned n);
        int unsigned b = 0;
        while (lat_q.size() < n && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        check($sformatf("wait_latch_%0d", n), 32'(lat_q.size() >= n), 32'd1);
    endtask

    task automatic wait_frames(input int unsigned n);
        int unsigned b = 0;
        while (fs_cyc_q.size() < n && b < 2000) begin
            @(posedge clk);
            #1;
            b++;
        end
        check($sformatf("wait_fs_%0d", n), 32'(fs_cyc_q.size() >= n), 32'd1);
    endtask

    logic [15:0] exp_word [6];

    initial begin
        exp_word[0] = 16'hA501;
        exp_word[1] = 16'h3F02;
        exp_word[2] = 16'h3F04;
        exp_word[3] = 16'h0008;
        exp_word[4] = 16'h3F10;
        exp_word[5] = 16'h3F20;

        rst_n       = 1'b0;
        bus.i_7seg  = 8'hA5;
        bus.i_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel",   bus.o_seg_select, 0);
        check("rst_sclk",  bus.o_sclk, 0);
        check("rst_sdata", bus.o_sdata, 0);
        check("rst_latch", bus.o_latch, 0);
        check("rst_fs",    bus.o_frame_start, 0);
        rst_n = 1'b1;

        // Change the segment byte mid-shift; the captured A5 must still be sent.
        wait_cyc(3);
        bus.i_7seg = 8'h3F;
        check("fs0_count", fs_cyc_q.size(), 1);
        if (fs_cyc_q.size() >= 1) begin
            check("fs0_cyc", fs_cyc_q[0], 1);
            check("fs0_sel", fs_sel_q[0], 0);
        end

        // Blank held from digit 2 dwell through digit 3 capture only.
        wait_cyc(113);
        bus.i_blank = 1'b1;
        wait_cyc(119);
        bus.i_blank = 1'b0;

        wait_latches(6);
        for (int d = 0; d < 6; d++) begin
            if (lat_q.size() > d) begin
                check($sformatf("word_d%0d", d),  lat_q[d].word, exp_word[d]);
                check($sformatf("nbits_d%0d", d), lat_q[d].nbits, 16);
                check($sformatf("lcyc_d%0d", d),  lat_q[d].cyc, 34 + 39 * d);
                check($sformatf("llen_d%0d", d),  lat_q[d].len, 1);
                check($sformatf("sel_d%0d", d),   lat_q[d].sel, d);
            end
        end

        wait_frames(2);
        check("fs1_count", fs_cyc_q.size(), 2);
        if (fs_cyc_q.size() >= 2) begin
            check("fs1_cyc", fs_cyc_q[1], 235);
            check("fs1_sel", fs_sel_q[1], 0);
        end

        // Reset in the middle of shift bit 7 of the second frame's digit 0.
        wait_cyc(250);
        check("pre_rst_sclk_low", bus.o_sclk, 0);
        rst_n = 1'b0;
        #1;
        check("async_sclk",  bus.o_sclk, 0);
        check("async_sdata", bus.o_sdata, 0);
        check("async_sel",   bus.o_seg_select, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_latch_count", lat_q.size(), 6);
        bus.i_7seg = 8'h5A;
        rst_n = 1'b1;

        wait_frames(3);
        if (fs_cyc_q.size() >= 3) begin
            check("fs2_cyc", fs_cyc_q[2], 1);
            check("fs2_sel", fs_sel_q[2], 0);
        end
        wait_cyc(33);
        check("no_early_latch", lat_q.size(), 6);
        wait_latches(7);
        if (lat_q.size() >= 7) begin
            check("restart_word",  lat_q[6].word, 16'h5A01);
            check("restart_nbits", lat_q[6].nbits, 16);
            check("restart_lcyc",  lat_q[6].cyc, 34);
            check("restart_llen",  lat_q[6].len, 1);
            check("restart_sel",   lat_q[6].sel, 0);
        end
        check("fs_total", fs_cyc_q.size(), 3);

        check("line_err", line_err, 0);
        check("rst_err",  rst_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
